// File: rtl/logic_gate_pipe.sv
`timescale 1ns/1ps
// logic_gate_pipe: two-stage, back-pressurable bitwise logic unit.
//   clk, rst              : rising-edge clock, async active-high reset
//   in_valid/in_ready     : input handshake; in_a, in_b, in_op carried together
//   out_valid/out_ready   : output handshake; out_data from the stage-2 register
//   out_cnt               : completed output transfers, wraps silently
//   busy                  : either pipeline stage holds valid data
module logic_gate_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_cnt,
  output logic             busy
);

  typedef enum logic [2:0] {
    OP_NOT  = 3'd0,
    OP_AND  = 3'd1,
    OP_OR   = 3'd2,
    OP_XOR  = 3'd3,
    OP_NAND = 3'd4,
    OP_NOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  op_e              s1_op_q, s1_op_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_data_q, s2_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             s2_free;
  logic             s1_move;
  logic             in_fire;
  logic             out_fire;
  logic [WIDTH-1:0] result;

  // Handshake/advance; in_ready is combinational from out_ready so a full
  // pipe can drain, shift and accept on the same edge.
  always_comb begin
    s2_free  = !s2_valid_q || out_ready;
    s1_move  = s1_valid_q && s2_free;
    in_ready = !s1_valid_q || s2_free;
    in_fire  = in_valid && in_ready;
    out_fire = s2_valid_q && out_ready;
  end

  always_comb begin
    result = '0;
    unique case (s1_op_q)
      OP_NOT:  result = ~s1_a_q;
      OP_AND:  result = s1_a_q & s1_b_q;
      OP_OR:   result = s1_a_q | s1_b_q;
      OP_XOR:  result = s1_a_q ^ s1_b_q;
      OP_NAND: result = ~(s1_a_q & s1_b_q);
      OP_NOR:  result = ~(s1_a_q | s1_b_q);
      OP_XNOR: result = ~(s1_a_q ^ s1_b_q);
      OP_PASS: result = s1_a_q;
      default: result = '0;
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    cnt_d      = cnt_q;

    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_a_d     = in_a;
      s1_b_d     = in_b;
      s1_op_d    = op_e'(in_op);
    end else if (s1_move) begin
      s1_valid_d = 1'b0;
    end

    if (s1_move) begin
      s2_valid_d = 1'b1;
      s2_data_d  = result;
    end else if (out_fire) begin
      s2_valid_d = 1'b0;
    end

    if (out_fire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= OP_NOT;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_op_q    <= s1_op_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    out_valid = s2_valid_q;
    out_data  = s2_data_q;
    out_cnt   = cnt_q;
    busy      = s1_valid_q || s2_valid_q;
  end

endmodule

// File: tb/tb_logic_gate_pipe.sv
`timescale 1ns/1ps
module tb_logic_gate_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] in_a, in_b;
  logic [2:0] in_op;

  logic       in_ready, out_valid, busy;
  logic [7:0] out_data;
  logic [15:0] out_cnt;
  logic       in_ready4, out_valid4, busy4;
  logic [7:0] out_data4;
  logic [3:0] out_cnt4;

  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;
  int cyc = 0;
  int c0;
  logic [7:0] sb[$];
  logic [7:0] first_exp;
  logic [7:0] tbl [8];
  logic [7:0] ra, rb;
  logic [2:0] rop;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  logic_gate_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_cnt(out_cnt), .busy(busy)
  );

  logic_gate_pipe #(.WIDTH(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid4),
    .out_ready(out_ready), .out_data(out_data4), .out_cnt(out_cnt4), .busy(busy4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0: return ~a;
      3'd1: return a & b;
      3'd2: return a | b;
      3'd3: return a ^ b;
      3'd4: return ~(a & b);
      3'd5: return ~(a | b);
      3'd6: return ~(a ^ b);
      default: return a;
    endcase
  endfunction

  // Output monitor: counter every cycle, scoreboard pop on each transfer.
  always @(negedge clk) begin
    if (!rst) begin
      chk("cnt16", 32'(out_cnt), 32'(exp_cnt % 65536));
      chk("cnt4", 32'(out_cnt4), 32'(exp_cnt % 16));
      chk("valid_pair", 32'(out_valid4), 32'(out_valid));
      if (out_valid && out_ready) begin
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          logic [7:0] e;
          e = sb.pop_front();
          chk("out_data", 32'(out_data), 32'(e));
          chk("out_data4", 32'(out_data4), 32'(e));
        end
        exp_cnt++;
      end
    end
  end

  task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
  endtask

  task automatic wait_accept(input logic [7:0] expv);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(expv);
        ok = 1'b1;
        @(posedge clk);
        #1;
        break;
      end
    end
    chk("accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic [7:0] expv);
    drive(op, a, b);
    wait_accept(expv);
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain_timeout", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = 8'h0F; tbl[1] = 8'hC0; tbl[2] = 8'hFC; tbl[3] = 8'h3C;
    tbl[4] = 8'h3F; tbl[5] = 8'h03; tbl[6] = 8'hC3; tbl[7] = 8'hF0;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_op = '0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_cnt", 32'(out_cnt), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;

    // Single NOT transfer
    send(3'd0, 8'hA5, 8'h00, 8'h5A);
    in_valid = 1'b0;
    @(negedge clk);
    chk("single_s1_no_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_data", 32'(out_data), 32'h5A);
    @(negedge clk);
    chk("single_valid_one_cycle", 32'(out_valid), 32'd0);
    chk("single_cnt", 32'(out_cnt), 32'd1);
    @(posedge clk);
    #1;

    // All eight ops back-to-back
    c0 = cyc;
    for (int i = 0; i < 8; i++) send(3'(i), 8'hF0, 8'hCC, tbl[i]);
    in_valid = 1'b0;
    chk("stream8_cycles", 32'(cyc - c0), 32'd8);
    drain();
    chk("stream8_cnt", 32'(out_cnt), 32'd9);

    // Backpressure: two fill the pipe, third waits
    out_ready = 1'b0;
    first_exp = model(3'd1, 8'h3C, 8'h0F);
    send(3'd1, 8'h3C, 8'h0F, first_exp);
    send(3'd2, 8'h3C, 8'h0F, model(3'd2, 8'h3C, 8'h0F));
    drive(3'd3, 8'h3C, 8'h0F);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_data_stable", 32'(out_data), 32'(first_exp));
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_accept(model(3'd3, 8'h3C, 8'h0F));
    in_valid = 1'b0;
    drain();
    chk("bp_cnt", 32'(out_cnt), 32'd12);

    // Sustained full-pipe streaming
    c0 = cyc;
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rop = 3'($urandom_range(0, 7));
      send(rop, ra, rb, model(rop, ra, rb));
    end
    in_valid = 1'b0;
    chk("stream20_cycles", 32'(cyc - c0), 32'd20);
    drain();
    chk("stream20_cnt", 32'(out_cnt), 32'd32);

    // Async reset with both stages full
    out_ready = 1'b0;
    send(3'd4, 8'hAA, 8'h0F, model(3'd4, 8'hAA, 8'h0F));
    send(3'd5, 8'hAA, 8'h0F, model(3'd5, 8'hAA, 8'h0F));
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_out_cnt", 32'(out_cnt), 32'd0);
    chk("arst_out_cnt4", 32'(out_cnt4), 32'd0);
    sb.delete();
    exp_cnt = 0;
    @(posedge clk);
    #2 rst = 1'b0;
    out_ready = 1'b1;
    c0 = cyc;
    send(3'd6, 8'h96, 8'h5A, 8'h33);
    in_valid = 1'b0;
    chk("post_rst_first_edge", 32'(cyc - c0), 32'd1);
    drain();
    chk("post_rst_cnt", 32'(out_cnt), 32'd1);

    // 4-bit counter wrap over 17 transfers
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    sb.delete();
    exp_cnt = 0;
    @(posedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 17; i++) send(3'd7, 8'(i), 8'hFF, 8'(i));
    in_valid = 1'b0;
    drain();
    chk("wrap_cnt4", 32'(out_cnt4), 32'd1);
    chk("wrap_cnt16", 32'(out_cnt), 32'd17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
